cic_interp: RTL and testbench

CIC interpolation filter: accepts one signed sample every `rate` enabled clocks and produces one filtered, upsampled sample on every enabled clock. It is the transmit-side counterpart of the CIC decimator in the DSP chain and uses the same `rate`/`len`/`width`/`width_ex` parameter set. Typical placement: between a low-rate sample source and a DAC or DSM feed running at full `clk` rate.

---
 rtl/cic_interp.sv | 100 ++++++++++
 tb/tb_cic_interp.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_interp.sv
// CIC interpolator: N low-rate combs, zero-stuffing by R, N high-rate integrators.
// Define CIC_INTERP_ROUND_EN for a round-half-up, saturating output stage.
module cic_interp #(
    parameter int rate     = 10,
    parameter int len      = 4,
    parameter int width    = 16,
    parameter int width_ex = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cke,
    input  logic [width-1:0] din,
    output logic             din_req,
    output logic [width-1:0] dout,
    output logic             cke_out
);

    localparam int W  = width + width_ex;
    localparam int CW = (rate > 1) ? $clog2(rate) : 1;

    typedef logic signed [W-1:0] word_t;

    logic [CW-1:0] cnt_q, cnt_d;
    word_t         comb_dly_q [len];
    word_t         comb_dly_d [len];
    word_t         integ_q    [len];
    word_t         integ_d    [len];
    word_t         zs_q, zs_d;
    logic          cke_out_q, cke_out_d;

    assign din_req = (cnt_q == '0);
    assign cke_out = cke_out_q;

    always_comb begin
        word_t x;
        x          = word_t'($signed(din));
        cnt_d      = cnt_q;
        comb_dly_d = comb_dly_q;
        integ_d    = integ_q;
        zs_d       = zs_q;
        cke_out_d  = cke;
        if (cke) begin
            cnt_d = (cnt_q == CW'(rate - 1)) ? '0 : cnt_q + CW'(1);
            if (din_req) begin
                for (int unsigned k = 0; k < len; k++) begin
                    comb_dly_d[k] = x;
                    x             = x - comb_dly_q[k];
                end
                zs_d = x;
            end else begin
                zs_d = '0;
            end
            // every integrator sees the pre-edge value of its predecessor
            integ_d[0] = integ_q[0] + zs_q;
            for (int unsigned k = 1; k < len; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            zs_q      <= '0;
            cke_out_q <= 1'b0;
            for (int unsigned k = 0; k < len; k++) begin
                comb_dly_q[k] <= '0;
                integ_q[k]    <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            zs_q      <= zs_d;
            cke_out_q <= cke_out_d;
            for (int unsigned k = 0; k < len; k++) begin
                comb_dly_q[k] <= comb_dly_d[k];
                integ_q[k]    <= integ_d[k];
            end
        end
    end

`ifdef CIC_INTERP_ROUND_EN
    generate
        if (width_ex > 0) begin : g_round
            localparam logic [W:0] HALF = (W + 1)'(1) << (width_ex - 1);
            logic [W:0] rnd;
            // one guard bit catches positive overflow of the rounded result
            always_comb begin
                rnd  = {integ_q[len-1][W-1], integ_q[len-1]} + HALF;
                dout = (rnd[W] != rnd[W-1]) ? {1'b0, {(width - 1){1'b1}}}
                                            : rnd[W-1:width_ex];
            end
        end else begin : g_trunc
            assign dout = integ_q[len-1][W-1:width_ex];
        end
    endgenerate
`else
    assign dout = integ_q[len-1][W-1:width_ex];
`endif

endmodule

// File: tb/tb_cic_interp.sv
// Scoreboard bench for cic_interp: default-parameter instance plus a
// rate=2/len=1/width_ex=0 instance.
module tb_cic_interp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cke, din_req, cke_out;
    logic [15:0] din, dout;
    logic        rst2, cke2, din_req2, cke_out2;
    logic [15:0] din2, dout2;

    cic_interp #(.rate(10), .len(4), .width(16), .width_ex(10)) u_dut (
        .clk(clk), .rst(rst), .cke(cke), .din(din),
        .din_req(din_req), .dout(dout), .cke_out(cke_out)
    );

    cic_interp #(.rate(2), .len(1), .width(16), .width_ex(0)) u_sw (
        .clk(clk), .rst(rst2), .cke(cke2), .din(din2),
        .din_req(din_req2), .dout(dout2), .cke_out(cke_out2)
    );

`ifdef CIC_INTERP_ROUND_EN
    localparam int DC_POS = 977;
`else
    localparam int DC_POS = 976;
`endif
    localparam int DC_NEG = -977;
    localparam int FS_POS = 31999;
    localparam int FS_NEG = -32000;

    typedef struct {
        logic chk;
        int   lo;
        int   hi;
        logic req;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp2_q[$];
    int   errors = 0;
    int   checks = 0;
    int   k_ph;
    int   sum_dout;
    int   h[40];
    logic sw_done = 1'b0;

    task automatic check_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected within [%0d,%0d]", name, act, lo, hi);
        end
    endtask

    // expected impulse response: four cascaded length-10 boxcars
    task automatic build_h();
        int tmp[40];
        int n;
        foreach (h[i]) h[i] = 0;
        h[0] = 1;
        n = 1;
        repeat (4) begin
            foreach (tmp[i]) tmp[i] = 0;
            for (int i = 0; i < n; i++)
                for (int j = 0; j < 10; j++) tmp[i+j] += h[i];
            n += 9;
            h = tmp;
        end
    endtask

    function automatic int imp_exp(input int k);
        if (k < 4 || k - 4 >= 37) return 0;
        return h[k-4];
    endfunction

    // one clock of stimulus; enabled cycles queue their expectation
    task automatic tick(input logic en, input int d, input logic chk, input int lo, input int hi);
        exp_t e;
        @(posedge clk);
        #2;
        cke = en;
        din = d[15:0];
        if (en) begin
            e.chk = chk;
            e.lo  = lo;
            e.hi  = hi;
            e.req = ((k_ph + 1) % 10 == 0);
            exp_q.push_back(e);
            k_ph++;
        end
    endtask

    task automatic stop_run();
        @(posedge clk);
        #2;
        cke = 1'b0;
        @(posedge clk);
        #4;
    endtask

    task automatic do_reset();
        stop_run();
        rst = 1'b0;
        #1;
        check_eq("rst_dout", int'($signed(dout)), 0);
        check_eq("rst_cke_out", int'(cke_out), 0);
        check_eq("rst_din_req", int'(din_req), 1);
        check_eq("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst      = 1'b1;
        k_ph     = 0;
        sum_dout = 0;
        #1;
        check_eq("post_rst_din_req", int'(din_req), 1);
    endtask

    task automatic run_impulse(input int gap);
        int e;
        for (int i = 0; i < 50; i++) begin
            e = imp_exp(i);
            tick(1'b1, (i == 0) ? 1024 : 0, 1'b1, e, e);
            repeat (gap) tick(1'b0, 0, 1'b0, 0, 0);
        end
        stop_run();
        check_eq("impulse_sum", sum_dout, 10000);
    endtask

    task automatic run_dc(input int d, input int fin);
        int lo, hi;
        lo = (fin < 0) ? fin : 0;
        hi = (fin < 0) ? 0 : fin;
        for (int i = 0; i < 50; i++) tick(1'b1, d, 1'b1, lo, hi);
        for (int i = 0; i < 20; i++) tick(1'b1, d, 1'b1, fin, fin);
        stop_run();
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   act;
        if (cke_out) begin
            act      = int'($signed(dout));
            sum_dout = sum_dout + act;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got dout=%0d, expected no output", act);
            end else begin
                e = exp_q.pop_front();
                check_eq("din_req_phase", int'(din_req), int'(e.req));
                if (e.chk) check_rng("dout", act, e.lo, e.hi);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (cke_out2) begin
            if (exp2_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sw_unexpected_output: got dout=%0d, expected no output", $signed(dout2));
            end else begin
                e = exp2_q.pop_front();
                check_eq("sw_din_req", int'(din_req2), int'(e.req));
                check_eq("sw_dout", int'($signed(dout2)), e.lo);
            end
        end
    end

    initial begin
        exp_t e;
        rst2 = 1'b0;
        cke2 = 1'b0;
        din2 = 16'd100;
        repeat (3) @(posedge clk);
        #2;
        rst2 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #2;
            cke2  = 1'b1;
            e.chk = 1'b1;
            e.lo  = (i == 0) ? 0 : 100;
            e.hi  = e.lo;
            e.req = ((i + 1) % 2 == 0);
            exp2_q.push_back(e);
        end
        @(posedge clk);
        #2;
        cke2 = 1'b0;
        @(posedge clk);
        #4;
        sw_done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        cke      = 1'b0;
        din      = '0;
        k_ph     = 0;
        sum_dout = 0;
        build_h();

        do_reset();
        run_impulse(0);

        // reset mid-stream, asserted between edges while cke_out is high
        do_reset();
        for (int i = 0; i < 37; i++) tick(1'b1, int'($urandom_range(0, 65535)), 1'b0, 0, 0);
        @(posedge clk);
        #7;
        rst = 1'b0;
        cke = 1'b0;
        #1;
        check_eq("mid_rst_dout", int'($signed(dout)), 0);
        check_eq("mid_rst_cke_out", int'(cke_out), 0);
        check_eq("mid_rst_din_req", int'(din_req), 1);
        exp_q.delete();
        @(posedge clk);
        #2;
        rst      = 1'b1;
        k_ph     = 0;
        sum_dout = 0;
        run_impulse(0);

        do_reset();
        run_impulse(2);

        do_reset();
        run_dc(1000, DC_POS);
        do_reset();
        run_dc(-1000, DC_NEG);
        do_reset();
        run_dc(32767, FS_POS);
        do_reset();
        run_dc(-32768, FS_NEG);

        for (int i = 0; i < 1000 && !sw_done; i++) @(posedge clk);
        check_eq("sw_done", int'(sw_done), 1);
        check_eq("queue_empty", exp_q.size(), 0);
        check_eq("sw_queue_empty", exp2_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
